spi_frame_master: RTL and testbench
===================================

// Module: spi_frame_master
// PURPOSE
//   Single-lane SPI master (mode 0, MSB first) for the transmit board: turns a
//   valid/ready word stream into framed SPI transfers on SCLK/MOSI/CS_n.
//   It drives one receive-board slave lane and captures MISO into a return stream.
//   The Tx top instantiates one per lane (4 lanes).
// PARAMETERS
//   DATA_W    32  bits per word shifted on the wire
//   CLK_DIV    4  sysclk cycles per SCLK half-period (>=1)
//   CS_SETUP   2  sysclk cycles from CS_n fall to start of first SCLK low half
//   CS_HOLD    2  sysclk cycles from last SCLK fall to CS_n rise
//   CS_IDLE    4  minimum sysclk cycles CS_n stays high between frames
// PORTS
//   sysclk   in   1       system clock; all logic on rising edge
//   rst      in   1       asynchronous, active-high reset
//   s_data   in   DATA_W  word to transmit
//   s_valid  in   1       s_data/s_last valid
//   s_last   in   1       word is the final word of the frame
//   s_ready  out  1       word accepted when s_valid & s_ready
//   rx_data  out  DATA_W  word captured from MISO
//   rx_valid out  1       one-cycle pulse; rx_data valid
//   busy     out  1       high in any state other than IDLE
//   SCLK     out  1       SPI clock; idles low
//   MOSI     out  1       SPI data out
//   MISO     in   1       SPI data in
//   CS_n     out  1       chip select, active low
// BEHAVIOUR
//   Reset: CS_n=1, SCLK=0, MOSI=0, s_ready=0, rx_valid=0, rx_data=0, busy=0,
//     state=IDLE. Mid-frame reset aborts immediately; no partial rx_valid.
//   s_ready = (state==IDLE) | (state==NEXT), combinational from state register.
//   FSM: IDLE, SETUP, SHIFT, NEXT, HOLD, GAP.
//   IDLE: on accept, load tx shift reg, set MOSI=s_data[DATA_W-1], CS_n=0,
//     latch s_last -> SETUP.
//   SETUP: CS_SETUP cycles with SCLK=0 -> SHIFT.
//   SHIFT: per bit, SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
//     - On the rising SCLK edge cycle: shift MISO into the rx reg LSB.
//     - On the falling edge cycle: shift the tx reg left and present the next
//       bit on MOSI.
//     - Bit period = 2*CLK_DIV cycles.
//     - After the DATA_W-th falling edge: rx_data <= rx reg and rx_valid=1 for
//       one cycle, in the same cycle as the transition to NEXT or HOLD.
//     - Next state: HOLD if the latched last=1, else NEXT.
//   NEXT: CS_n stays 0, SCLK=0, MOSI holds its last bit. Stalls indefinitely
//     until accept; accept loads the new word and MOSI, then -> SHIFT (no SETUP).
//   HOLD: CS_HOLD cycles, CS_n=0, SCLK=0 -> GAP with CS_n=1.
//   GAP: CS_IDLE cycles, CS_n=1 -> IDLE.
//   Latencies:
//     - Accept in IDLE -> first SCLK rise = CS_SETUP+CLK_DIV cycles.
//     - Single-word frame CS_n low time = CS_SETUP + 2*CLK_DIV*DATA_W + CS_HOLD.
//   Counters: half-period counter ceil(log2(CLK_DIV+1)) bits; bit counter
//     ceil(log2(DATA_W+1)) bits; both cleared on state entry; no wrap beyond
//     terminal count.
//   No rx back-pressure: the consumer must take rx_valid when pulsed.
//   SCLK, MOSI and CS_n are registered outputs (glitch-free).
// TESTING (DATA_W=8, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_IDLE=4)
//   1. Word 0xA5, last=1, MISO looped to MOSI -> MOSI at rising edges 1,0,1,0,
//      0,1,0,1; CS_n low exactly 36 cycles; rx_data=0xA5, one rx_valid pulse.
//   2. 3-word frame 0x01,0x80,0xFF, s_valid back-to-back -> CS_n low
//      continuously; 24 SCLK rises; 3 rx_valid pulses.
//   3. Same frame with a 10-cycle s_valid gap before word 2 -> CS_n stays 0,
//      SCLK stays 0 for the gap; bit timing resumes intact.
//   4. Two 1-word frames offered back-to-back -> CS_n high >= 4 cycles between
//      them; s_ready=0 throughout HOLD and GAP.
//   5. rst asserted mid-bit 4 -> CS_n=1, SCLK=0 without waiting for a clock
//      edge; no rx_valid; a new frame afterwards starts cleanly.
//   6. MISO tied high, word 0x00 -> rx_data=0xFF; MOSI low for all 16 half-periods.

Source files
------------

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - mode-0 MSB-first SPI frame master with framed CS_n
// Streams s_data words onto MOSI and returns the MISO word of each transfer on rx_data.
`timescale 1ns/1ps
module spi_frame_master #(
   parameter int DATA_W   = 32,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic              sysclk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic              CS_n
);
   localparam int HALF_W  = $clog2(CLK_DIV + 1);
   localparam int BIT_W   = $clog2(DATA_W + 1);
   localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ?
                            ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                            ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;

   state_t              state_q, state_d;
   logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   // Only the bits still to be sent; the MSB goes straight to MOSI on accept.
   logic [DATA_W-2:0]   tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                last_q, last_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic                cs_n_q, cs_n_d;
   logic                accept;

   // Gated by rst so s_ready reads low while reset is held.
   assign s_ready  = ~rst & ((state_q == IDLE) | (state_q == NEXT));
   assign accept   = s_valid & s_ready;
   assign busy     = (state_q != IDLE);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign SCLK     = sclk_q;
   assign MOSI     = mosi_q;
   assign CS_n     = cs_n_q;

   always_comb begin
      state_d    = state_q;
      half_cnt_d = half_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tmr_d      = tmr_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      last_d     = last_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tx_sr_d = s_data[DATA_W-2:0];
               mosi_d  = s_data[DATA_W-1];
               cs_n_d  = 1'b0;
               last_d  = s_last;
               tmr_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
               half_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = SHIFT;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         SHIFT: begin
            if (half_cnt_q != HALF_W'(CLK_DIV - 1)) begin
               half_cnt_d = half_cnt_q + HALF_W'(1);
            end else begin
               half_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  rx_sr_d = {rx_sr_q[DATA_W-2:0], MISO};
               end else begin
                  sclk_d = 1'b0;
                  // On the final fall MOSI keeps the last bit for the NEXT stall.
                  if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                     rx_data_d  = rx_sr_q;
                     rx_valid_d = 1'b1;
                     tmr_d      = '0;
                     state_d    = last_q ? HOLD : NEXT;
                  end else begin
                     mosi_d    = tx_sr_q[DATA_W-2];
                     tx_sr_d   = tx_sr_q << 1;
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end
            end
         end
         NEXT: begin
            if (accept) begin
               tx_sr_d    = s_data[DATA_W-2:0];
               mosi_d     = s_data[DATA_W-1];
               last_d     = s_last;
               half_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = SHIFT;
            end
         end
         HOLD: begin
            if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
               cs_n_d  = 1'b1;
               tmr_d   = '0;
               state_d = GAP;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         GAP: begin
            if (tmr_q == TMR_W'(CS_IDLE - 1)) begin
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         half_cnt_q <= '0;
         bit_cnt_q  <= '0;
         tmr_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         last_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         half_cnt_q <= half_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tmr_q      <= tmr_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         last_q     <= last_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
      end
   end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - randomized self-checking bench for spi_frame_master
// A negedge monitor records SCLK/MOSI/CS_n/rx activity; tasks compare it to a word-level model.
`timescale 1ns/1ps
module tb_spi_frame_master;
   localparam int DW  = 8;
   localparam int CD  = 2;
   localparam int CSS = 2;
   localparam int CSH = 2;
   localparam int CSI = 4;
   localparam int WORD_CYC = 2 * CD * DW;

   logic          sysclk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          busy;
   logic          SCLK;
   logic          MOSI;
   logic          MISO;
   logic          CS_n;
   int            miso_mode = 0;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] frame_w [0:15];

   logic          mosi_bits[$];
   logic [DW-1:0] rx_q[$];
   int            cs_len_q[$];
   int            first_lat_q[$];
   int            gap_q[$];
   int            bad_timing, total_rises, mosi_hi_cnt, ready_busy_cnt;
   int            cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, last_rise = 0, rises_in_frame = 0;
   logic          prev_cs = 1'b1, prev_sclk = 1'b0, prev_rxv = 1'b0, seen_cs_rise = 1'b0;

   assign MISO = (miso_mode == 0) ? MOSI : 1'b1;

   always #5 sysclk = ~sysclk;

   spi_frame_master #(
      .DATA_W(DW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)
   ) dut (
      .sysclk(sysclk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_n(CS_n)
   );

   always @(negedge sysclk) begin
      if (rst) begin
         prev_cs = 1'b1;
         prev_sclk = 1'b0;
         prev_rxv = 1'b0;
         seen_cs_rise = 1'b0;
      end else begin
         if (!CS_n && prev_cs) begin
            cs_fall_cyc = cyc;
            rises_in_frame = 0;
            if (seen_cs_rise) gap_q.push_back(cyc - cs_rise_cyc);
         end
         if (CS_n && !prev_cs) begin
            cs_len_q.push_back(cyc - cs_fall_cyc);
            cs_rise_cyc = cyc;
            seen_cs_rise = 1'b1;
         end
         if (SCLK && !prev_sclk) begin
            mosi_bits.push_back(MOSI);
            if (rises_in_frame == 0) first_lat_q.push_back(cyc - cs_fall_cyc);
            else if ((rises_in_frame % DW) != 0 && (cyc - last_rise) != 2 * CD) bad_timing++;
            rises_in_frame++;
            total_rises++;
            last_rise = cyc;
         end
         if (!SCLK && prev_sclk && (cyc - last_rise) != CD) bad_timing++;
         if (SCLK && CS_n) bad_timing++;
         if (rx_valid) rx_q.push_back(rx_data);
         if (rx_valid && prev_rxv) bad_timing++;
         if (!CS_n && MOSI) mosi_hi_cnt++;
         if (s_ready && busy) ready_busy_cnt++;
         prev_cs = CS_n;
         prev_sclk = SCLK;
         prev_rxv = rx_valid;
      end
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      mosi_bits.delete();
      rx_q.delete();
      cs_len_q.delete();
      first_lat_q.delete();
      gap_q.delete();
      bad_timing = 0;
      total_rises = 0;
      mosi_hi_cnt = 0;
      ready_busy_cnt = 0;
      seen_cs_rise = 1'b0;
   endtask

   // Model: the wire carries every word MSB first, words in offer order.
   function automatic int bit_mismatch(input int n);
      int idx = 0;
      int mm = 0;
      if (mosi_bits.size() != n * DW) return -1;
      for (int k = 0; k < n; k++)
         for (int b = DW - 1; b >= 0; b--) begin
            if (mosi_bits[idx] !== frame_w[k][b]) mm++;
            idx++;
         end
      return mm;
   endfunction

   // Model: looped MISO returns each sent word, MISO high returns all ones.
   function automatic int rx_mismatch(input int n);
      int mm = 0;
      logic [DW-1:0] exp_w;
      if (rx_q.size() != n) return -1;
      for (int k = 0; k < n; k++) begin
         exp_w = (miso_mode == 0) ? frame_w[k] : {DW{1'b1}};
         if (rx_q[k] !== exp_w) mm++;
      end
      return mm;
   endfunction

   task automatic send_frame(input int n, input int stall_idx, input int stall_len,
                             input int gap, input int flen);
      int cnt;
      for (int k = 0; k < n; k++) begin
         if (k == stall_idx && stall_len > 0) begin
            cnt = 0;
            while (!rx_valid && cnt < 2000) begin @(negedge sysclk); cnt++; end
            repeat (stall_len) @(negedge sysclk);
         end else begin
            repeat (gap) @(negedge sysclk);
         end
         s_data = frame_w[k];
         s_last = (((k + 1) % flen) == 0) || (k == n - 1);
         s_valid = 1'b1;
         cnt = 0;
         while (!s_ready && cnt < 2000) begin @(negedge sysclk); cnt++; end
         tests++;
         if (!s_ready) begin
            fails++;
            $display("FAIL accept_timeout word %0d: s_ready=%b, required 1", k, s_ready);
         end
         @(negedge sysclk);
         s_valid = 1'b0;
         s_last = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int cnt = 0;
      while (busy && cnt < 2000) begin @(negedge sysclk); cnt++; end
      tests++;
      if (busy) begin
         fails++;
         $display("FAIL idle_timeout: busy=%b, required 0", busy);
      end
      repeat (2) @(negedge sysclk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge sysclk);
      tests++;
      if ({CS_n, SCLK, MOSI, s_ready, rx_valid, busy} !== 6'b100000) begin
         fails++;
         $display("FAIL reset_ctrl: {CS_n,SCLK,MOSI,s_ready,rx_valid,busy}=%b, required 100000",
                  {CS_n, SCLK, MOSI, s_ready, rx_valid, busy});
      end
      tests++;
      if (rx_data !== '0) begin
         fails++;
         $display("FAIL reset_rx_data: got %h, required 00", rx_data);
      end
      rst = 1'b0;
      @(negedge sysclk);
      tests++;
      if (s_ready !== 1'b1) begin
         fails++;
         $display("FAIL idle_s_ready: got %b, required 1", s_ready);
      end
   endtask

   task automatic test_single_word();
      int mm;
      int got;
      clear_mon();
      miso_mode = 0;
      frame_w[0] = 8'hA5;
      send_frame(1, -1, 0, 0, 1);
      wait_idle();
      mm = bit_mismatch(1);
      tests++;
      if (mm !== 0) begin fails++; $display("FAIL single_mosi: mismatches %0d, required 0", mm); end
      got = (cs_len_q.size() == 1) ? cs_len_q[0] : -1;
      tests++;
      if (got !== CSS + WORD_CYC + CSH) begin
         fails++;
         $display("FAIL single_cs_low: got %0d, required %0d", got, CSS + WORD_CYC + CSH);
      end
      mm = rx_mismatch(1);
      tests++;
      if (mm !== 0) begin fails++; $display("FAIL single_rx: mismatches %0d, required 0", mm); end
      got = (first_lat_q.size() == 1) ? first_lat_q[0] : -1;
      tests++;
      if (got !== CSS + CD) begin
         fails++;
         $display("FAIL first_rise_latency: got %0d, required %0d", got, CSS + CD);
      end
      tests++;
      if (bad_timing !== 0) begin fails++; $display("FAIL single_timing: violations %0d, required 0", bad_timing); end
   endtask

   task automatic test_multi_word();
      int mm;
      int got;
      clear_mon();
      frame_w[0] = 8'h01; frame_w[1] = 8'h80; frame_w[2] = 8'hFF;
      send_frame(3, -1, 0, 0, 3);
      wait_idle();
      got = (cs_len_q.size() == 1) ? cs_len_q[0] : -1;
      tests++;
      if (got !== CSS + 3 * WORD_CYC + 2 + CSH) begin
         fails++;
         $display("FAIL multi_cs_low: got %0d, required %0d", got, CSS + 3 * WORD_CYC + 2 + CSH);
      end
      tests++;
      if (total_rises !== 3 * DW) begin fails++; $display("FAIL multi_rises: got %0d, required %0d", total_rises, 3 * DW); end
      mm = rx_mismatch(3);
      tests++;
      if (mm !== 0) begin fails++; $display("FAIL multi_rx: mismatches %0d, required 0", mm); end
      mm = bit_mismatch(3);
      tests++;
      if (mm !== 0) begin fails++; $display("FAIL multi_mosi: mismatches %0d, required 0", mm); end
   endtask

   task automatic test_stall();
      int mm;
      int got;
      clear_mon();
      frame_w[0] = 8'h01; frame_w[1] = 8'h80; frame_w[2] = 8'hFF;
      send_frame(3, 1, 10, 0, 3);
      wait_idle();
      got = (cs_len_q.size() == 1) ? cs_len_q[0] : -1;
      tests++;
      if (got !== CSS + 3 * WORD_CYC + 11 + 1 + CSH) begin
         fails++;
         $display("FAIL stall_cs_low: got %0d, required %0d", got, CSS + 3 * WORD_CYC + 12 + CSH);
      end
      tests++;
      if (total_rises !== 3 * DW || bad_timing !== 0) begin
         fails++;
         $display("FAIL stall_timing: rises %0d violations %0d, required %0d and 0", total_rises, bad_timing, 3 * DW);
      end
      mm = rx_mismatch(3) + bit_mismatch(3);
      tests++;
      if (mm !== 0) begin fails++; $display("FAIL stall_data: mismatches %0d, required 0", mm); end
   endtask

   task automatic test_back_to_back();
      int mm;
      clear_mon();
      frame_w[0] = 8'($urandom);
      frame_w[1] = 8'($urandom);
      send_frame(2, -1, 0, 0, 1);
      wait_idle();
      tests++;
      if (cs_len_q.size() !== 2 || gap_q.size() !== 1) begin
         fails++;
         $display("FAIL b2b_frames: cs frames %0d gaps %0d, required 2 and 1", cs_len_q.size(), gap_q.size());
      end else begin
         tests++;
         if (cs_len_q[0] !== CSS + WORD_CYC + CSH || cs_len_q[1] !== CSS + WORD_CYC + CSH) begin
            fails++;
            $display("FAIL b2b_cs_low: got %0d/%0d, required %0d", cs_len_q[0], cs_len_q[1], CSS + WORD_CYC + CSH);
         end
         tests++;
         if (gap_q[0] < CSI) begin fails++; $display("FAIL b2b_cs_gap: got %0d, required >= %0d", gap_q[0], CSI); end
      end
      tests++;
      if (ready_busy_cnt !== 0) begin
         fails++;
         $display("FAIL b2b_ready_in_hold_gap: cycles %0d, required 0", ready_busy_cnt);
      end
      mm = rx_mismatch(2) + bit_mismatch(2);
      tests++;
      if (mm !== 0) begin fails++; $display("FAIL b2b_data: mismatches %0d, required 0", mm); end
   endtask

   task automatic test_reset_mid();
      int cnt;
      int mm;
      clear_mon();
      s_data = 8'hC3;
      s_last = 1'b1;
      s_valid = 1'b1;
      cnt = 0;
      while (!s_ready && cnt < 100) begin @(negedge sysclk); cnt++; end
      @(negedge sysclk);
      s_valid = 1'b0;
      s_last = 1'b0;
      repeat (CSS + CD + 3 * 2 * CD + 1) @(negedge sysclk);
      tests++;
      if (SCLK !== 1'b1 || CS_n !== 1'b0) begin
         fails++;
         $display("FAIL mid_bit_state: SCLK=%b CS_n=%b, required 1 and 0", SCLK, CS_n);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({CS_n, SCLK, busy} !== 3'b100) begin
         fails++;
         $display("FAIL async_reset: {CS_n,SCLK,busy}=%b, required 100", {CS_n, SCLK, busy});
      end
      repeat (3) @(negedge sysclk);
      rst = 1'b0;
      repeat (40) @(negedge sysclk);
      tests++;
      if (rx_q.size() !== 0 || CS_n !== 1'b1) begin
         fails++;
         $display("FAIL reset_no_rx: rx pulses %0d CS_n=%b, required 0 and 1", rx_q.size(), CS_n);
      end
      clear_mon();
      frame_w[0] = 8'h5A;
      send_frame(1, -1, 0, 0, 1);
      wait_idle();
      mm = rx_mismatch(1) + bit_mismatch(1);
      tests++;
      if (mm !== 0 || cs_len_q.size() !== 1) begin
         fails++;
         $display("FAIL post_reset_frame: mismatches %0d frames %0d, required 0 and 1", mm, cs_len_q.size());
      end
   endtask

   task automatic test_miso_high();
      int mm;
      clear_mon();
      miso_mode = 1;
      frame_w[0] = 8'h00;
      send_frame(1, -1, 0, 0, 1);
      wait_idle();
      mm = rx_mismatch(1);
      tests++;
      if (mm !== 0) begin
         fails++;
         $display("FAIL miso_high_rx: got %h, required ff", (rx_q.size() > 0) ? rx_q[0] : 8'h00);
      end
      tests++;
      if (mosi_hi_cnt !== 0 || total_rises !== DW) begin
         fails++;
         $display("FAIL miso_high_mosi: high cycles %0d rises %0d, required 0 and %0d", mosi_hi_cnt, total_rises, DW);
      end
      miso_mode = 0;
   endtask

   task automatic test_random();
      int n;
      int gap;
      int mm;
      int got;
      for (int f = 0; f < 10; f++) begin
         clear_mon();
         n = $urandom_range(1, 3);
         gap = $urandom_range(0, 4);
         for (int k = 0; k < n; k++) frame_w[k] = 8'($urandom);
         send_frame(n, -1, 0, gap, n);
         wait_idle();
         got = (cs_len_q.size() == 1) ? cs_len_q[0] : -1;
         tests++;
         if (got !== CSS + n * WORD_CYC + (n - 1) + CSH) begin
            fails++;
            $display("FAIL rand_cs_low frame %0d: got %0d, required %0d", f, got, CSS + n * WORD_CYC + (n - 1) + CSH);
         end
         mm = rx_mismatch(n) + bit_mismatch(n);
         tests++;
         if (mm !== 0 || bad_timing !== 0) begin
            fails++;
            $display("FAIL rand_data frame %0d: mismatches %0d violations %0d, required 0 and 0", f, mm, bad_timing);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_multi_word();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_miso_high();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
